// File: rtl/sim_mem_port_if.sv
// -----------------------------------------------------------------------------
// sim_mem_port_if
//   Core-side command/response bus of the simulation memory port.
//
//   Parameters
//     ADDR_W : command byte-address width
//     DATA_W : response data width (32 or 64)
//
//   Signals
//     cmd_valid / cmd_ready : request handshake, accepted when both are high
//     cmd_addr              : byte address
//     cmd_wen               : 1 = write, 0 = read
//     cmd_wdata / cmd_wstrb : RAM-word aligned write data and byte strobes
//     rsp_valid / rsp_ready : read-response handshake
//     rsp_data              : read data
//
//   Modports
//     master : the core (drives commands, consumes responses)
//     slave  : the memory port
// -----------------------------------------------------------------------------
interface sim_mem_port_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_wen;
  logic [63:0]       cmd_wdata;
  logic [7:0]        cmd_wstrb;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_addr, cmd_wen, cmd_wdata, cmd_wstrb, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_wen, cmd_wdata, cmd_wstrb, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/sim_mem_port.sv
// -----------------------------------------------------------------------------
// sim_mem_port
//   Simulation memory port: turns a core cmd/rsp valid/ready bus into
//   RAMHelper-style word-array accesses. Writes are performed at the accept
//   edge and produce no response. Reads capture the RAM word at accept and
//   queue it in an in-order FIFO together with a 10-bit cycle stamp; the head
//   is presented once it has aged LATENCY cycles and is held until consumed.
//
//   Parameters
//     DATA_W    : response data width, 32 or 64
//     ADDR_W    : command address width
//     IDX_W     : RAM word-index width
//     BASE_ADDR : byte address mapped to RAM index 0
//     LATENCY   : cycles from accept to earliest rsp_valid, 1..1023
//     DEPTH     : maximum outstanding reads, power of 2, 2..16
//
//   Ports
//     clock, reset : clock and synchronous active-high reset
//     bus          : sim_mem_port_if.slave (cmd_* / rsp_* handshakes)
//     ram_en       : RAM access enable (accepted command)
//     ram_idx      : RAM word index, shared by read and write
//     ram_rdata    : RAM read data, combinational from ram_idx
//     ram_wdata    : RAM write data
//     ram_wmask    : RAM write bit mask (each strobe bit widened to a byte)
//     ram_wen      : RAM write enable
//     outstanding  : number of queued reads
//
//   Optional build macro
//     SIM_MEM_RANDOM_STALL_EN : adds a 16-bit Galois LFSR (seed 16'hACE1,
//     x^16+x^14+x^13+x^11+1) that forces cmd_ready low whenever its two low
//     bits are 00, to stress core stall paths.
// -----------------------------------------------------------------------------
module sim_mem_port #(
  parameter int          DATA_W    = 64,
  parameter int          ADDR_W    = 64,
  parameter int          IDX_W     = 28,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int          LATENCY   = 1,
  parameter int          DEPTH     = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  sim_mem_port_if.slave            bus,
  output logic                     ram_en,
  output logic [IDX_W-1:0]         ram_idx,
  input  logic [63:0]              ram_rdata,
  output logic [63:0]              ram_wdata,
  output logic [63:0]              ram_wmask,
  output logic                     ram_wen,
  output logic [$clog2(DEPTH):0]   outstanding
);

  localparam int                PTR_W    = $clog2(DEPTH);
  localparam int                CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
  localparam logic [9:0]        LAT_C    = 10'(LATENCY);
  localparam logic [ADDR_W-1:0] BASE_C   = ADDR_W'(BASE_ADDR);

  generate
    if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
      $error("sim_mem_port: DATA_W must be 32 or 64");
    end
    if (LATENCY < 1 || LATENCY > 1023) begin : g_bad_latency
      $error("sim_mem_port: LATENCY must be in 1..1023");
    end
    if (DEPTH < 2 || DEPTH > 16 || (1 << PTR_W) != DEPTH) begin : g_bad_depth
      $error("sim_mem_port: DEPTH must be a power of 2 in 2..16");
    end
  endgenerate

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [9:0]        stamp;
  } entry_t;

  entry_t            fifo_q [DEPTH];
  entry_t            head;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [9:0]        cycle;
  logic [9:0]        head_age;
  logic              head_seen;
  logic              stall;
  logic              full;
  logic              empty;
  logic              accept;
  logic              push;
  logic              pop;
  logic              eligible;
  logic              rsp_valid_int;
  logic [DATA_W-1:0] rd_word;

  // ---------------------------------------------------------------------------
  // Optional random stall source
  // ---------------------------------------------------------------------------
`ifdef SIM_MEM_RANDOM_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Command side
  // ---------------------------------------------------------------------------
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // A full queue only blocks reads; writes never occupy a slot. The ready
  // decision looks at the current count only, so a pop does not free a slot
  // until the following cycle.
  assign bus.cmd_ready = !stall && (!full || bus.cmd_wen);

  assign accept = bus.cmd_valid && bus.cmd_ready && !reset;
  assign push   = accept && !bus.cmd_wen;

  assign ram_en    = accept;
  assign ram_wen   = accept && bus.cmd_wen;
  assign ram_idx   = IDX_W'((bus.cmd_addr - BASE_C) >> 3);
  assign ram_wdata = bus.cmd_wdata;

  always_comb begin
    ram_wmask = '0;
    for (int i = 0; i < 8; i++) begin
      ram_wmask[8*i +: 8] = {8{bus.cmd_wstrb[i]}};
    end
  end

  // Narrow ports return the half of the RAM word selected by address bit 2.
  generate
    if (DATA_W == 32) begin : g_w32
      assign rd_word = bus.cmd_addr[2] ? ram_rdata[63:32] : ram_rdata[31:0];
    end else begin : g_w64
      assign rd_word = ram_rdata;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Response side
  // ---------------------------------------------------------------------------
  assign head     = fifo_q[rd_ptr];
  assign head_age = cycle - head.stamp;
  assign eligible = (head_age >= LAT_C);

  // head_seen keeps an already-presented head valid even if the 10-bit age
  // wraps during a long backpressure stall, so rsp_valid never drops early.
  assign rsp_valid_int = !empty && (eligible || head_seen);
  assign pop           = rsp_valid_int && bus.rsp_ready;

  assign bus.rsp_valid = rsp_valid_int;
  assign bus.rsp_data  = rsp_valid_int ? head.data : '0;
  assign outstanding   = count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      cycle     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      head_seen <= 1'b0;
    end else begin
      cycle     <= cycle + 10'd1;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count     <= count + CNT_W'(push) - CNT_W'(pop);
      head_seen <= rsp_valid_int && !pop;
    end
  end

  // NOTE: the FIFO storage is deliberately not reset; entries are only
  // observable through the count/pointers, which are reset, and rsp_data is
  // gated to zero while nothing is valid.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_q[wr_ptr] <= '{data: rd_word, stamp: cycle};
    end
  end

endmodule

// File: tb/tb_sim_mem_port.sv
// -----------------------------------------------------------------------------
// tb_sim_mem_port
//   Directed self-checking bench for sim_mem_port (default build, random
//   stall disabled). Two instances are exercised one after the other:
//     u_dut_a : DATA_W=32, LATENCY=1, DEPTH=4
//     u_dut_b : DATA_W=64, LATENCY=5, DEPTH=4
//   Each instance has a small behavioural RAM (16 words, combinational read,
//   masked write on the clock edge). Inputs are driven and outputs sampled
//   just after the falling edge.
// -----------------------------------------------------------------------------
module tb_sim_mem_port;

  logic clock = 1'b0;
  logic reset;
  logic ram_clr;

  always #5 clock = ~clock;

  sim_mem_port_if #(.ADDR_W(64), .DATA_W(32)) bus_a ();
  sim_mem_port_if #(.ADDR_W(64), .DATA_W(64)) bus_b ();

  logic        ram_en_a, ram_wen_a, ram_en_b, ram_wen_b;
  logic [27:0] ram_idx_a, ram_idx_b;
  logic [63:0] ram_rdata_a, ram_wdata_a, ram_wmask_a;
  logic [63:0] ram_rdata_b, ram_wdata_b, ram_wmask_b;
  logic [2:0]  outstanding_a, outstanding_b;

  sim_mem_port #(
    .DATA_W(32), .ADDR_W(64), .IDX_W(28), .BASE_ADDR(64'h8000_0000),
    .LATENCY(1), .DEPTH(4)
  ) u_dut_a (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus_a),
    .ram_en     (ram_en_a),
    .ram_idx    (ram_idx_a),
    .ram_rdata  (ram_rdata_a),
    .ram_wdata  (ram_wdata_a),
    .ram_wmask  (ram_wmask_a),
    .ram_wen    (ram_wen_a),
    .outstanding(outstanding_a)
  );

  sim_mem_port #(
    .DATA_W(64), .ADDR_W(64), .IDX_W(28), .BASE_ADDR(64'h8000_0000),
    .LATENCY(5), .DEPTH(4)
  ) u_dut_b (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus_b),
    .ram_en     (ram_en_b),
    .ram_idx    (ram_idx_b),
    .ram_rdata  (ram_rdata_b),
    .ram_wdata  (ram_wdata_b),
    .ram_wmask  (ram_wmask_b),
    .ram_wen    (ram_wen_b),
    .outstanding(outstanding_b)
  );

  // Behavioural RAMs
  logic [63:0] mem_a [16];
  logic [63:0] mem_b [16];

  assign ram_rdata_a = mem_a[ram_idx_a[3:0]];
  assign ram_rdata_b = mem_b[ram_idx_b[3:0]];

  always @(posedge clock) begin
    if (ram_clr) begin
      for (int i = 0; i < 16; i++) begin
        mem_a[i] <= '0;
        mem_b[i] <= '0;
      end
    end else begin
      if (ram_wen_a) begin
        mem_a[ram_idx_a[3:0]] <= (mem_a[ram_idx_a[3:0]] & ~ram_wmask_a) | (ram_wdata_a & ram_wmask_a);
      end
      if (ram_wen_b) begin
        mem_b[ram_idx_b[3:0]] <= (mem_b[ram_idx_b[3:0]] & ~ram_wmask_b) | (ram_wdata_b & ram_wmask_b);
      end
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic drive_a(input logic v, input logic [63:0] addr, input logic wen,
                         input logic [63:0] wdata, input logic [7:0] wstrb);
    bus_a.cmd_valid = v;
    bus_a.cmd_addr  = addr;
    bus_a.cmd_wen   = wen;
    bus_a.cmd_wdata = wdata;
    bus_a.cmd_wstrb = wstrb;
  endtask

  task automatic drive_b(input logic v, input logic [63:0] addr, input logic wen,
                         input logic [63:0] wdata, input logic [7:0] wstrb);
    bus_b.cmd_valid = v;
    bus_b.cmd_addr  = addr;
    bus_b.cmd_wen   = wen;
    bus_b.cmd_wdata = wdata;
    bus_b.cmd_wstrb = wstrb;
  endtask

  initial begin
    int acc;
    int n;
    logic [63:0] rd_addr [4];

    reset   = 1'b1;
    ram_clr = 1'b1;
    drive_a(1'b0, 64'h8000_0000, 1'b0, '0, '0);
    drive_b(1'b0, 64'h8000_0000, 1'b0, '0, '0);
    bus_a.rsp_ready = 1'b1;
    bus_b.rsp_ready = 1'b1;
    tick();
    tick();

    // ---------------- Reset state ----------------
    drive_a(1'b1, 64'h8000_0000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    #1;
    check("a_ram_en_in_reset", ram_en_a, 0);
    check("a_ram_wen_in_reset", ram_wen_a, 0);
    drive_a(1'b0, 64'h8000_0000, 1'b0, '0, '0);
    tick();
    reset   = 1'b0;
    ram_clr = 1'b0;
    #1;
    check("a_rst_rsp_valid", bus_a.rsp_valid, 0);
    check("a_rst_rsp_data", bus_a.rsp_data, 0);
    check("a_rst_outstanding", outstanding_a, 0);
    check("a_rst_cmd_ready", bus_a.cmd_ready, 1);

    // Preload two RAM words through instance A
    drive_a(1'b1, 64'h8000_0000, 1'b1, 64'h1111_2222_3333_4444, 8'hFF);
    #1;
    check("a_wr_ram_en", ram_en_a, 1);
    check("a_wr_ram_wen", ram_wen_a, 1);
    check("a_wr_wmask_full", ram_wmask_a, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    drive_a(1'b1, 64'h8000_0008, 1'b1, 64'h5555_6666_7777_8888, 8'hFF);
    #1;
    check("a_wr1_idx", ram_idx_a, 1);
    tick();

    // ---------------- Single / back-to-back reads (32-bit) ----------------
    drive_a(1'b1, 64'h8000_0004, 1'b0, '0, '0);
    #1;
    check("a_rd_idx", ram_idx_a, 0);
    check("a_rd_ready", bus_a.cmd_ready, 1);
    check("a_rd_no_rsp_yet", bus_a.rsp_valid, 0);
    check("a_rd_wen_low", ram_wen_a, 0);
    tick();
    drive_a(1'b1, 64'h8000_0000, 1'b0, '0, '0);
    #1;
    check("a_rd_hi_valid", bus_a.rsp_valid, 1);
    check("a_rd_hi_data", bus_a.rsp_data, 64'h1111_2222);
    tick();
    drive_a(1'b0, 64'h8000_0000, 1'b0, '0, '0);
    #1;
    check("a_rd_lo_valid", bus_a.rsp_valid, 1);
    check("a_rd_lo_data", bus_a.rsp_data, 64'h3333_4444);
    tick();
    #1;
    check("a_rd_done_valid", bus_a.rsp_valid, 0);
    check("a_rd_done_outstanding", outstanding_a, 0);

    // ---------------- Full and backpressure ----------------
    rd_addr[0] = 64'h8000_0000;
    rd_addr[1] = 64'h8000_0004;
    rd_addr[2] = 64'h8000_0008;
    rd_addr[3] = 64'h8000_000C;
    bus_a.rsp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      drive_a(1'b1, (acc < 4) ? rd_addr[acc] : 64'h8000_0000, 1'b0, '0, '0);
      #1;
      if (bus_a.cmd_ready) acc++;
      tick();
    end
    drive_a(1'b0, 64'h8000_0000, 1'b0, '0, '0);
    #1;
    check("full_accepted", acc, 4);
    check("full_outstanding", outstanding_a, 4);
    check("full_cmd_ready", bus_a.cmd_ready, 0);
    check("full_rsp_valid", bus_a.rsp_valid, 1);
    check("full_rsp_data_held", bus_a.rsp_data, 64'h3333_4444);
    // A write is still accepted while reads are blocked and takes no slot.
    drive_a(1'b1, 64'h8000_0038, 1'b1, 64'h0, 8'hFF);
    #1;
    check("full_write_ready", bus_a.cmd_ready, 1);
    check("full_write_wen", ram_wen_a, 1);
    tick();
    drive_a(1'b0, 64'h8000_0000, 1'b0, '0, '0);
    bus_a.rsp_ready = 1'b1;
    #1;
    check("full_after_write_outstanding", outstanding_a, 4);
    check("drain_no_bypass_ready", bus_a.cmd_ready, 0);
    check("drain_d0", bus_a.rsp_data, 64'h3333_4444);
    tick();
    #1;
    check("drain_ready_after_pop", bus_a.cmd_ready, 1);
    check("drain_outstanding_3", outstanding_a, 3);
    check("drain_d1", bus_a.rsp_data, 64'h1111_2222);
    tick();
    #1;
    check("drain_d2", bus_a.rsp_data, 64'h7777_8888);
    tick();
    #1;
    check("drain_d3", bus_a.rsp_data, 64'h5555_6666);
    tick();
    #1;
    check("drain_empty_valid", bus_a.rsp_valid, 0);
    check("drain_empty_outstanding", outstanding_a, 0);

    // ---------------- Reset mid-operation ----------------
    bus_a.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_a(1'b1, rd_addr[i], 1'b0, '0, '0);
      tick();
    end
    drive_a(1'b0, 64'h8000_0000, 1'b0, '0, '0);
    #1;
    check("midrst_pre_outstanding", outstanding_a, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("midrst_outstanding", outstanding_a, 0);
    check("midrst_rsp_valid", bus_a.rsp_valid, 0);
    check("midrst_rsp_data", bus_a.rsp_data, 0);
    check("midrst_cmd_ready", bus_a.cmd_ready, 1);
    bus_a.rsp_ready = 1'b1;
    drive_a(1'b1, 64'h8000_000C, 1'b0, '0, '0);
    tick();
    drive_a(1'b0, 64'h8000_0000, 1'b0, '0, '0);
    #1;
    check("midrst_new_valid", bus_a.rsp_valid, 1);
    check("midrst_new_data", bus_a.rsp_data, 64'h5555_6666);
    tick();
    #1;
    check("midrst_no_stale", bus_a.rsp_valid, 0);

    // ---------------- Write then read (64-bit, LATENCY=5) ----------------
    drive_b(1'b1, 64'h8000_0010, 1'b1, 64'hDEAD_BEEF_0000_0000, 8'hF0);
    #1;
    check("b_wr_wmask", ram_wmask_b, 64'hFFFF_FFFF_0000_0000);
    check("b_wr_wen", ram_wen_b, 1);
    check("b_wr_idx", ram_idx_b, 2);
    check("b_wr_wdata", ram_wdata_b, 64'hDEAD_BEEF_0000_0000);
    tick();
    drive_b(1'b1, 64'h8000_0010, 1'b0, '0, '0);
    #1;
    check("b_wr_no_rsp", bus_b.rsp_valid, 0);
    check("b_wr_no_slot", outstanding_b, 0);
    tick();
    drive_b(1'b0, 64'h8000_0000, 1'b0, '0, '0);
    n = 1;
    #1;
    while (!bus_b.rsp_valid && n < 20) begin
      tick();
      n++;
      #1;
    end
    check("b_rd_latency", n, 5);
    check("b_rd_data", bus_b.rsp_data, 64'hDEAD_BEEF_0000_0000);
    tick();

    // Preload idx 4..6 for the latency sequence
    for (int i = 0; i < 3; i++) begin
      drive_b(1'b1, 64'h8000_0020 + 64'(8 * i), 1'b1, 64'hA000_0000_0000_0000 + 64'(i), 8'hFF);
      tick();
    end
    drive_b(1'b0, 64'h8000_0000, 1'b0, '0, '0);

    // ---------------- Latency: accepts at cycles 10,11,12 ----------------
    reset = 1'b1;
    tick();
    reset = 1'b0;                       // cycle counter reads 0 here
    for (int i = 0; i < 10; i++) tick(); // cycle 10
    for (int i = 0; i < 3; i++) begin
      drive_b(1'b1, 64'h8000_0020 + 64'(8 * i), 1'b0, '0, '0);
      tick();
    end
    drive_b(1'b0, 64'h8000_0000, 1'b0, '0, '0);
    #1;
    check("lat_c13_outstanding", outstanding_b, 3);
    check("lat_c13_valid", bus_b.rsp_valid, 0);
    tick();
    #1;
    check("lat_c14_valid", bus_b.rsp_valid, 0);
    tick();
    #1;
    check("lat_c15_valid", bus_b.rsp_valid, 1);
    check("lat_c15_data", bus_b.rsp_data, 64'hA000_0000_0000_0000);
    tick();
    #1;
    check("lat_c16_valid", bus_b.rsp_valid, 1);
    check("lat_c16_data", bus_b.rsp_data, 64'hA000_0000_0000_0001);
    tick();
    #1;
    check("lat_c17_valid", bus_b.rsp_valid, 1);
    check("lat_c17_data", bus_b.rsp_data, 64'hA000_0000_0000_0002);
    tick();
    #1;
    check("lat_c18_valid", bus_b.rsp_valid, 0);
    check("lat_c18_outstanding", outstanding_b, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
